// File: rtl/calc_defs.sv
// Shared calculator definitions: register func codes, instruction op codes,
// ULA select codes, control-unit state encoding and the control output bundle.
package calc_defs;

  localparam int unsigned FUNC_W = 3;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_HOLD   = 3'b000,
    FUNC_LOAD   = 3'b001,
    FUNC_SHIFTR = 3'b010,
    FUNC_SHIFTL = 3'b011,
    FUNC_RESET  = 3'b100
  } func_t;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 3'b000,
    OP_LOADX = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_SHR   = 3'b100,
    OP_SHL   = 3'b101,
    OP_CLR   = 3'b110,
    OP_MOVZ  = 3'b111
  } op_t;

  // Code 2'b11 is deliberately left unassigned and is never driven.
  typedef enum logic [SEL_W-1:0] {
    SEL_ADD    = 2'b00,
    SEL_SUB    = 2'b01,
    SEL_PASS_Y = 2'b10
  } sel_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_EXEC = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  typedef struct packed {
    func_t func_x;
    func_t func_y;
    func_t func_z;
    sel_t  sel_ula;
    logic  busy;
    logic  done;
  } ctrl_t;

  localparam ctrl_t CTRL_INIT = '{
    func_x: FUNC_RESET, func_y: FUNC_RESET, func_z: FUNC_RESET,
    sel_ula: SEL_ADD, busy: 1'b1, done: 1'b0
  };

endpackage

// File: rtl/unidade_controle.sv
// Calculator control unit: one instruction per start/done handshake, issuing
// X/Y/Z register commands and the ULA select, with a counter for multi-cycle shifts.
module unidade_controle
  import calc_defs::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [CNT_W-1:0]  n,
  output logic [FUNC_W-1:0] funcX,
  output logic [FUNC_W-1:0] funcY,
  output logic [FUNC_W-1:0] funcZ,
  output logic [SEL_W-1:0]  selULA,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  op_t               opr_q, opr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ctrl_t             ctrl_q, ctrl_d;

  // Next state, latched instruction and shift counter.
  always_comb begin
    state_d = state_q;
    opr_d   = opr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (start) begin
          opr_d   = op_t'(op);
          cnt_d   = n;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if ((opr_q == OP_SHR || opr_q == OP_SHL) && cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  // Moore decode of the upcoming state so the registered outputs line up with it.
  always_comb begin
    ctrl_d = '{
      func_x: FUNC_HOLD, func_y: FUNC_HOLD, func_z: FUNC_HOLD,
      sel_ula: SEL_ADD, busy: 1'b1, done: 1'b0
    };
    case (state_d)
      ST_INIT: ctrl_d = CTRL_INIT;
      ST_IDLE: ctrl_d.busy = 1'b0;
      ST_DONE: ctrl_d.done = 1'b1;
      ST_EXEC: begin
        case (opr_d)
          OP_LOADX: ctrl_d.func_x = FUNC_LOAD;
          OP_ADD:   ctrl_d.func_y = FUNC_LOAD;
          OP_SUB: begin
            ctrl_d.sel_ula = SEL_SUB;
            ctrl_d.func_y  = FUNC_LOAD;
          end
          OP_SHR:   ctrl_d.func_y = FUNC_SHIFTR;
          OP_SHL:   ctrl_d.func_y = FUNC_SHIFTL;
          OP_CLR: begin
            ctrl_d.func_x = FUNC_RESET;
            ctrl_d.func_y = FUNC_RESET;
            ctrl_d.func_z = FUNC_RESET;
          end
          OP_MOVZ: begin
            ctrl_d.sel_ula = SEL_PASS_Y;
            ctrl_d.func_z  = FUNC_LOAD;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      opr_q   <= OP_NOP;
      cnt_q   <= '0;
      ctrl_q  <= CTRL_INIT;
    end else begin
      state_q <= state_d;
      opr_q   <= opr_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign funcX  = ctrl_q.func_x;
  assign funcY  = ctrl_q.func_y;
  assign funcZ  = ctrl_q.func_z;
  assign selULA = ctrl_q.sel_ula;
  assign busy   = ctrl_q.busy;
  assign done   = ctrl_q.done;

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench for unidade_controle: each scenario queues per-cycle stimulus
// with the expected output vector {funcX,funcY,funcZ,selULA,busy,done}.
module tb_unidade_controle;

  logic       clock = 1'b0;
  logic       reset, start;
  logic [2:0] op;
  logic [1:0] n;
  logic [2:0] funcX, funcY, funcZ;
  logic [1:0] selULA;
  logic       busy, done;

  unidade_controle dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .n(n),
    .funcX(funcX), .funcY(funcY), .funcZ(funcZ), .selULA(selULA),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       r;
    logic       s;
    logic [2:0] o;
    logic [1:0] nn;
  } stim_t;

  stim_t       stim_q[$];
  logic [12:0] sb[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [12:0] mk(input logic [2:0] fx, input logic [2:0] fy,
                                     input logic [2:0] fz, input logic [1:0] sel,
                                     input logic b, input logic d);
    return {fx, fy, fz, sel, b, d};
  endfunction

  localparam logic [12:0] V_INIT = {3'd4, 3'd4, 3'd4, 2'd0, 1'b1, 1'b0};
  localparam logic [12:0] V_IDLE = {3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
  localparam logic [12:0] V_DONE = {3'd0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1};
  localparam logic [12:0] V_SHR  = {3'd0, 3'd2, 3'd0, 2'd0, 1'b1, 1'b0};
  localparam logic [12:0] V_SHL  = {3'd0, 3'd3, 3'd0, 2'd0, 1'b1, 1'b0};
  localparam logic [12:0] V_LDX  = {3'd1, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0};

  // Expected EXEC-cycle outputs straight from the instruction table.
  function automatic logic [12:0] exec_vec(input logic [2:0] o);
    case (o)
      3'd0:    return mk(3'd0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0);
      3'd1:    return mk(3'd1, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0);
      3'd2:    return mk(3'd0, 3'd1, 3'd0, 2'd0, 1'b1, 1'b0);
      3'd3:    return mk(3'd0, 3'd1, 3'd0, 2'd1, 1'b1, 1'b0);
      3'd4:    return mk(3'd0, 3'd2, 3'd0, 2'd0, 1'b1, 1'b0);
      3'd5:    return mk(3'd0, 3'd3, 3'd0, 2'd0, 1'b1, 1'b0);
      3'd6:    return mk(3'd4, 3'd4, 3'd4, 2'd0, 1'b1, 1'b0);
      default: return mk(3'd0, 3'd0, 3'd1, 2'd2, 1'b1, 1'b0);
    endcase
  endfunction

  function automatic logic [12:0] outs();
    return {funcX, funcY, funcZ, selULA, busy, done};
  endfunction

  task automatic push(input logic r, input logic s, input logic [2:0] o,
                      input logic [1:0] nn, input logic [12:0] e);
    stim_q.push_back('{r: r, s: s, o: o, nn: nn});
    sb.push_back(e);
  endtask

  task automatic apply(input stim_t st);
    reset = st.r;
    start = st.s;
    op    = st.o;
    n     = st.nn;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    push(1'b1, 1'b0, 3'd0, 2'd0, V_INIT);
    push(1'b1, 1'b1, 3'd1, 2'd0, V_INIT);
    push(1'b0, 1'b1, 3'd1, 2'd0, V_IDLE);
    push(1'b0, 1'b0, 3'd0, 2'd0, V_IDLE);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL reset cycle: got %h expected %h", outs(), e);
      end
    end
  endtask

  task automatic test_single_ops();
    logic [12:0] e;
    for (int o = 0; o < 8; o++) begin
      push(1'b0, 1'b1, 3'(o), (o == 4 || o == 5) ? 2'd0 : 2'($urandom_range(0, 3)), exec_vec(3'(o)));
      push(1'b0, 1'b0, 3'($urandom), 2'($urandom), V_DONE);
      push(1'b0, 1'b0, 3'($urandom), 2'($urandom), V_IDLE);
    end
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL single op t=%0t: got %h expected %h", $time, outs(), e);
      end
    end
  endtask

  task automatic test_shift();
    logic [12:0] e;
    push(1'b0, 1'b1, 3'd5, 2'd3, V_SHL);
    push(1'b0, 1'b0, 3'd6, 2'd0, V_SHL);
    push(1'b0, 1'b0, 3'd4, 2'd1, V_SHL);
    push(1'b0, 1'b0, 3'd0, 2'd2, V_SHL);
    push(1'b0, 1'b0, 3'd0, 2'd0, V_DONE);
    push(1'b0, 1'b0, 3'd0, 2'd0, V_IDLE);
    push(1'b0, 1'b1, 3'd4, 2'd1, V_SHR);
    push(1'b0, 1'b0, 3'd5, 2'd3, V_SHR);
    push(1'b0, 1'b0, 3'd0, 2'd0, V_DONE);
    push(1'b0, 1'b0, 3'd0, 2'd0, V_IDLE);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL shift t=%0t: got %h expected %h", $time, outs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    for (int k = 0; k < 3; k++) begin
      push(1'b0, 1'b1, 3'd1, 2'd0, V_LDX);
      push(1'b0, 1'b1, 3'd1, 2'd0, V_DONE);
      push(1'b0, 1'b1, 3'd1, 2'd0, V_IDLE);
    end
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL back_to_back t=%0t: got %h expected %h", $time, outs(), e);
      end
    end
    start = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_busy_reject();
    logic [12:0] e;
    push(1'b0, 1'b1, 3'd4, 2'd2, V_SHR);
    push(1'b0, 1'b1, 3'd6, 2'd0, V_SHR);
    push(1'b0, 1'b0, 3'd6, 2'd0, V_SHR);
    push(1'b0, 1'b1, 3'd6, 2'd3, V_DONE);
    push(1'b0, 1'b1, 3'd6, 2'd0, V_IDLE);
    push(1'b0, 1'b0, 3'd0, 2'd0, V_IDLE);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL busy_reject t=%0t: got %h expected %h", $time, outs(), e);
      end
    end
  endtask

  task automatic test_reset_mid_shr();
    logic [12:0] e;
    push(1'b0, 1'b1, 3'd4, 2'd3, V_SHR);
    push(1'b0, 1'b0, 3'd0, 2'd0, V_SHR);
    push(1'b1, 1'b0, 3'd0, 2'd0, V_INIT);
    push(1'b0, 1'b0, 3'd0, 2'd0, V_IDLE);
    push(1'b0, 1'b0, 3'd0, 2'd0, V_IDLE);
    push(1'b0, 1'b1, 3'd5, 2'd0, V_SHL);
    push(1'b0, 1'b0, 3'd0, 2'd0, V_DONE);
    push(1'b0, 1'b0, 3'd0, 2'd0, V_IDLE);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL reset_mid_shr t=%0t: got %h expected %h", $time, outs(), e);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    n     = 2'd0;
    test_reset();
    test_single_ops();
    test_shift();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid_shr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
